// File: rtl/hdc_pkg.sv
// Shared types and width helpers for the hyperdimensional multi-class classifier.
package hdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_ARGMIN = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width able to hold the value n itself (e.g. a full-width Hamming distance).
  function automatic int count_width(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int cnt_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/hdc_popcount.sv
// Combinational population count of a W-bit vector.
module hdc_popcount
  import hdc_pkg::*;
#(
  parameter int W = 500,
  localparam int CW = count_width(W)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(din[i]);
    end
  end

endmodule

// File: rtl/hdc_mc_classifier.sv
// Multi-class HDC classifier: trains per-class saturating bundling counters and
// infers by chunked Hamming-distance scan followed by a sequential argmin.
module hdc_mc_classifier
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS  = 10000,
  parameter int NUM_CLASSES = 4,
  parameter int CHUNK_W     = 500,
  parameter int CNT_W       = 8,
  localparam int NUM_CHUNKS = DIMENSIONS / CHUNK_W,
  localparam int LBL_W      = clog2_min1(NUM_CLASSES),
  localparam int DIST_W     = count_width(DIMENSIONS)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op,
  input  logic [LBL_W-1:0]      train_label,
  input  logic [DIMENSIONS-1:0] in_hv,
  output logic                  out_valid,
  output logic [LBL_W-1:0]      pred_label,
  output logic [DIST_W-1:0]     pred_dist,
  output logic                  train_err,
  input  logic [LBL_W-1:0]      rd_sel,
  output logic [DIMENSIONS-1:0] rd_hv,
  output state_e                dbg_state
);

  localparam int CHK_W = clog2_min1(NUM_CHUNKS);
  localparam int PC_W  = count_width(CHUNK_W);
  localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MIN_V = CNT_W'(cnt_min(CNT_W));

  if (DIMENSIONS % CHUNK_W != 0) begin : g_bad_chunk
    $error("DIMENSIONS must be a multiple of CHUNK_W");
  end
  if (NUM_CLASSES < 2) begin : g_bad_classes
    $error("NUM_CLASSES must be at least 2");
  end

  // Handshake: a request transfers on a rising edge with in_valid && in_ready;
  // in_ready is high only in IDLE, and out_valid is a single-cycle pulse.
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q [NUM_CLASSES][DIMENSIONS];
  logic [CNT_W-1:0]        cnt_d [NUM_CLASSES][DIMENSIONS];
  logic [DIMENSIONS-1:0]   query_q, query_d;
  logic [DIST_W-1:0]       acc_q [NUM_CLASSES];
  logic [DIST_W-1:0]       acc_d [NUM_CLASSES];
  logic [CHK_W-1:0]        chunk_q, chunk_d;
  logic [LBL_W-1:0]        cls_q, cls_d;
  logic [LBL_W-1:0]        best_lbl_q, best_lbl_d;
  logic [DIST_W-1:0]       best_dist_q, best_dist_d;
  logic [LBL_W-1:0]        pred_label_q, pred_label_d;
  logic [DIST_W-1:0]       pred_dist_q, pred_dist_d;
  logic                    train_err_q, train_err_d;

  logic [DIMENSIONS-1:0]   class_hv [NUM_CLASSES];
  logic [CHUNK_W-1:0]      q_chunk;
  logic [CHUNK_W-1:0]      c_chunk [NUM_CLASSES];
  logic [PC_W-1:0]         pc [NUM_CLASSES];
  logic                    accept;
  logic                    label_ok;
  logic [DIST_W-1:0]       cur_dist;

  assign accept     = in_valid && in_ready;
  assign label_ok   = int'(train_label) < NUM_CLASSES;
  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign pred_label = pred_label_q;
  assign pred_dist  = pred_dist_q;
  assign train_err  = train_err_q;
  assign dbg_state  = state_q;

  // A class bit is set when its counter is non-negative (sign bit clear).
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int i = 0; i < DIMENSIONS; i++) begin
        class_hv[c][i] = ~cnt_q[c][i][CNT_W-1];
      end
    end
  end

  always_comb begin
    rd_hv = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (rd_sel == LBL_W'(c)) rd_hv = class_hv[c];
    end
  end

  always_comb begin
    q_chunk = query_q[chunk_q*CHUNK_W +: CHUNK_W];
    for (int c = 0; c < NUM_CLASSES; c++) begin
      c_chunk[c] = class_hv[c][chunk_q*CHUNK_W +: CHUNK_W];
    end
  end

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_pc
    hdc_popcount #(.W(CHUNK_W)) u_popcount (
      .din (q_chunk ^ c_chunk[g]),
      .cnt (pc[g])
    );
  end

  // Bundling update: only the addressed class moves, one saturating step per bit.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !op && label_ok) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (c == int'(train_label)) begin
          for (int i = 0; i < DIMENSIONS; i++) begin
            if (in_hv[i] && cnt_q[c][i] != CNT_MAX_V) begin
              cnt_d[c][i] = cnt_q[c][i] + CNT_W'(1);
            end else if (!in_hv[i] && cnt_q[c][i] != CNT_MIN_V) begin
              cnt_d[c][i] = cnt_q[c][i] - CNT_W'(1);
            end
          end
        end
      end
    end
  end

  always_comb begin
    cur_dist = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (cls_q == LBL_W'(c)) cur_dist = acc_q[c];
    end
  end

  always_comb begin
    state_d      = state_q;
    query_d      = query_q;
    acc_d        = acc_q;
    chunk_d      = chunk_q;
    cls_d        = cls_q;
    best_lbl_d   = best_lbl_q;
    best_dist_d  = best_dist_q;
    pred_label_d = pred_label_q;
    pred_dist_d  = pred_dist_q;
    train_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op) begin
            query_d = in_hv;
            chunk_d = '0;
            for (int c = 0; c < NUM_CLASSES; c++) acc_d[c] = '0;
            state_d = ST_SCAN;
          end else if (!label_ok) begin
            train_err_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
          acc_d[c] = acc_q[c] + DIST_W'(pc[c]);
        end
        chunk_d = chunk_q + CHK_W'(1);
        if (chunk_q == CHK_W'(NUM_CHUNKS - 1)) begin
          cls_d   = '0;
          state_d = ST_ARGMIN;
        end
      end
      ST_ARGMIN: begin
        // Strict less-than keeps the lowest index on ties.
        if (cls_q == '0 || cur_dist < best_dist_q) begin
          best_lbl_d  = cls_q;
          best_dist_d = cur_dist;
        end
        cls_d = cls_q + LBL_W'(1);
        if (cls_q == LBL_W'(NUM_CLASSES - 1)) begin
          pred_label_d = best_lbl_d;
          pred_dist_d  = best_dist_d;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      query_q      <= '0;
      chunk_q      <= '0;
      cls_q        <= '0;
      best_lbl_q   <= '0;
      best_dist_q  <= '0;
      pred_label_q <= '0;
      pred_dist_q  <= '0;
      train_err_q  <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c] <= '0;
        for (int i = 0; i < DIMENSIONS; i++) cnt_q[c][i] <= '1;
      end
    end else begin
      state_q      <= state_d;
      query_q      <= query_d;
      chunk_q      <= chunk_d;
      cls_q        <= cls_d;
      best_lbl_q   <= best_lbl_d;
      best_dist_q  <= best_dist_d;
      pred_label_q <= pred_label_d;
      pred_dist_q  <= pred_dist_d;
      train_err_q  <= train_err_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hdc_mc_classifier.sv
// Directed bench for hdc_mc_classifier: 16-bit hypervectors, 4-bit chunks,
// three classes, 3-bit counters.
module tb_hdc_mc_classifier;
  import hdc_pkg::*;

  localparam int DIM  = 16;
  localparam int NCLS = 3;
  localparam int CHW  = 4;
  localparam int CW   = 3;
  localparam int LAT  = DIM / CHW + NCLS + 1;

  logic          clk;
  logic          nrst;
  logic          in_valid;
  logic          in_ready;
  logic          op;
  logic [1:0]    train_label;
  logic [15:0]   in_hv;
  logic          out_valid;
  logic [1:0]    pred_label;
  logic [4:0]    pred_dist;
  logic          train_err;
  logic [1:0]    rd_sel;
  logic [15:0]   rd_hv;
  state_e        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  hdc_mc_classifier #(
    .DIMENSIONS  (DIM),
    .NUM_CLASSES (NCLS),
    .CHUNK_W     (CHW),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .train_label (train_label),
    .in_hv       (in_hv),
    .out_valid   (out_valid),
    .pred_label  (pred_label),
    .pred_dist   (pred_dist),
    .train_err   (train_err),
    .rd_sel      (rd_sel),
    .rd_hv       (rd_hv),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reads back class c combinationally (called at a negedge).
  task automatic check_hv(input string tag, input int c, input logic [15:0] exp);
    rd_sel = 2'(c);
    #1;
    check(tag, 32'(rd_hv), 32'(exp));
  endtask

  // driver: one training request, occupies exactly one clock edge
  task automatic do_train(input logic [1:0] lbl, input logic [15:0] hv);
    in_valid    = 1'b1;
    op          = 1'b0;
    train_label = lbl;
    in_hv       = hv;
    @(negedge clk);
    in_valid    = 1'b0;
  endtask

  // driver + checker: one inference, with latency and result checks
  task automatic do_infer(input string tag, input logic [15:0] hv,
                          input logic [1:0] exp_lbl, input logic [4:0] exp_dist);
    int cyc;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op       = 1'b1;
    in_hv    = hv;
    @(negedge clk);
    in_valid = 1'b0;
    in_hv    = 16'($urandom_range(0, 65535));
    cyc      = 1;
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    check({tag, "_label"}, 32'(pred_label), 32'(exp_lbl));
    check({tag, "_dist"}, 32'(pred_dist), 32'(exp_dist));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(out_valid), 32'd0);
    check({tag, "_hold"}, 32'({pred_label, pred_dist}), 32'({exp_lbl, exp_dist}));
  endtask

  initial begin
    int pulses;
    in_valid    = 1'b0;
    op          = 1'b0;
    train_label = '0;
    in_hv       = '0;
    rd_sel      = '0;
    nrst        = 1'b0;
    @(negedge clk);
    apply_reset();

    // reset state
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_train_err", 32'(train_err), 32'd0);
    check("rst_pred", 32'({pred_label, pred_dist}), 32'd0);
    for (int c = 0; c < NCLS; c++) check_hv($sformatf("rst_hv%0d", c), c, 16'h0000);
    check_hv("rst_hv_oor", 3, 16'h0000);

    // all classes zero: tie at distance 4, lowest index wins
    do_infer("inf_zero", 16'h000F, 2'd0, 5'd4);

    // one training pass sets class 1 to all ones
    do_train(2'd1, 16'hFFFF);
    check_hv("tr1_hv1", 1, 16'hFFFF);
    check_hv("tr1_hv0", 0, 16'h0000);
    do_infer("inf_c1", 16'hFFF0, 2'd1, 5'd4);

    // class 2 counters: -1 -> +3 (saturates), then down toward -4
    for (int k = 0; k < 5; k++) do_train(2'd2, 16'hFFFF);
    check_hv("sat_up_hv2", 2, 16'hFFFF);
    for (int k = 0; k < 3; k++) do_train(2'd2, 16'h0000);
    check_hv("sat_up_3down", 2, 16'hFFFF);
    do_train(2'd2, 16'h0000);
    check_hv("sat_up_4down", 2, 16'h0000);
    for (int k = 0; k < 4; k++) do_train(2'd2, 16'h0000);
    check_hv("sat_dn_hv2", 2, 16'h0000);
    // counters now at -4: three ones reach -1, the fourth reaches 0
    for (int k = 0; k < 3; k++) do_train(2'd2, 16'hFFFF);
    check_hv("sat_dn_3up", 2, 16'h0000);
    do_train(2'd2, 16'hFFFF);
    check_hv("sat_dn_4up", 2, 16'hFFFF);
    do_train(2'd2, 16'h0000);
    check_hv("back_to_zero", 2, 16'h0000);

    // out-of-range label: error pulse, memory untouched
    do_train(2'd3, 16'hFFFF);
    check("bad_lbl_err", 32'(train_err), 32'd1);
    check_hv("bad_lbl_hv0", 0, 16'h0000);
    check_hv("bad_lbl_hv1", 1, 16'hFFFF);
    check_hv("bad_lbl_hv2", 2, 16'h0000);
    @(negedge clk);
    check("bad_lbl_err_pulse", 32'(train_err), 32'd0);
    check("good_lbl_no_err", 32'(train_err), 32'd0);

    // classes 0 and 2 tie at distance 1
    do_infer("inf_tie", 16'h0001, 2'd0, 5'd1);
    // mixed pattern spanning all chunks: class 0 dist 8, class 1 dist 8, class 2 dist 8
    do_infer("inf_mixed", 16'hA5A5, 2'd0, 5'd8);
    // query close to class 1 with a difference in the last chunk only
    do_infer("inf_last_chunk", 16'h7FFF, 2'd1, 5'd1);
    check_hv("inf_mem_kept", 1, 16'hFFFF);

    // reset during the third SCAN cycle aborts the inference
    in_valid = 1'b1;
    op       = 1'b1;
    in_hv    = 16'h00FF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_in_scan", 32'(dbg_state), 32'(ST_SCAN));
    nrst = 1'b0;
    @(negedge clk);
    nrst   = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    check("abort_no_out", 32'(pulses), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_pred", 32'({pred_label, pred_dist}), 32'd0);
    for (int c = 0; c < NCLS; c++) check_hv($sformatf("abort_hv%0d", c), c, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
